perm_in_loader: RTL and testbench
=================================

// Module: perm_in_loader
// PURPOSE
//  Upstream stage of perm_blk. Accepts the 64-bit lane stream from the NoC interface
//  (pushin/firstin/din, with stopin backpressure) and writes each 25-lane state into one of
//  two m55 banks (ping-pong). Offers each complete bank to the permutation core with a
//  valid/ready handshake, and reclaims the bank on a release pulse.
//  Loading of bank N+1 overlaps permutation of bank N.
// PARAMETERS
//  W      64  lane width, bits
//  LANES  25  lanes per block (5x5)
// PORTS
//  clk        in   1   clock, all state rising-edge
//  rst        in   1   reset, asynchronous, active-high
//  pushin     in   1   din valid this cycle
//  firstin    in   1   din is lane 0 of a new block
//  din        in   W   lane data
//  stopin     out  1   upstream must not push next cycle
//  m0wx,m0wy  out  3   bank0 write coordinates
//  m0wr       out  1   bank0 write enable
//  m0wd       out  W   bank0 write data
//  m1wx,m1wy  out  3   bank1 write coordinates
//  m1wr       out  1   bank1 write enable
//  m1wd       out  W   bank1 write data
//  blk_valid  out  1   a FULL bank is offered to the core
//  blk_bank   out  1   index of the offered bank
//  blk_ready  in   1   core takes the offered bank this cycle
//  rel        in   1   core finished with bank rel_bank
//  rel_bank   in   1   bank being released
//  err        out  1   one-cycle pulse on any protocol error
// BEHAVIOUR
//  - Reset values: stopin=0, m*wr=0, m*wx/wy/wd=0, blk_valid=0, blk_bank=0, err=0.
//    Both banks EMPTY; fill bank=0; lane count=0. Reset mid-block discards all contents.
//  - Per-bank state: EMPTY -> FILLING (accepted firstin) -> FULL (lane 24 written)
//    -> BUSY (blk_valid&blk_ready) -> EMPTY (rel with matching rel_bank).
//  - Lane mapping: lane i -> x=i%5, y=i/5. Counter runs 0..24; x and y are kept as
//    separate wrap counters, with no divide.
//  - Write latency: 1 cycle. An accepted push at cycle t gives mNwr=1 at t+1 with
//    registered x, y and data. The other bank's wr is 0.
//  - firstin accepted only if the fill bank is EMPTY, or is FILLING with count>0.
//    In the FILLING case the partial block is aborted, err pulses, and the new lane is
//    written as lane 0 of the same bank.
//  - pushin without firstin while the fill bank is EMPTY: word dropped, err pulses.
//  - Lane 24 write issued: that bank goes FULL next cycle. The fill pointer toggles and
//    count resets to 0.
//  - stopin is registered. It is 1 when the next fill bank is not EMPTY, i.e. both banks
//    are FULL/BUSY, or the current bank completes this cycle while the other is non-EMPTY.
//    A push while stopin=1 is dropped and err pulses.
//  - blk_valid = some bank FULL. Bank 0 has priority if both are FULL; order is kept
//    because the fill pointer alternates. blk_valid and blk_bank stay stable until ready.
//    blk_ready while blk_valid=0 is ignored.
//  - rel for a bank not BUSY: ignored, err pulses.
//  - rel and a transition on the same bank in the same cycle: rel is applied first, and
//    EMPTY is visible to stopin on the next edge.
//  - Simultaneous completion of one bank and rel of the other: both take effect, and stopin
//    stays 0.
// STRUCTURE
//  - perm_types_pkg: lane_t (logic[W-1:0]), coord_t (logic[2:0]), LANES,
//    bank_st_e {EMPTY,FILLING,FULL,BUSY}.
//  - One sub-module, perm_bank_ctl: one instance per bank, holding that bank's state
//    register.
//  - The top level holds the fill pointer, lane counters, write-port registers, offer
//    mux and error logic.
// TESTING
//  - Reset then firstin+24 pushes (din=i) -> m0wr at lanes (0,0)..(4,4), din 5 lands at
//    (0,1). blk_valid=1, blk_bank=0 two cycles after the last push.
//  - Two back-to-back blocks with blk_ready low -> second block fills bank1. After its
//    last push, stopin=1. A 51st push is dropped and err pulses.
//  - blk_ready then rel(0) -> bank0 EMPTY, stopin drops the next cycle, and the third
//    block writes m0 again.
//  - firstin at lane 10 -> err pulses, new din written at (0,0) of the same bank, and
//    blk_valid stays 0 until 25 lanes follow.
//  - pushin without firstin after reset -> no mNwr, err=1 for one cycle. rel(1) while
//    bank1 EMPTY -> err, no state change.
//  - Assert rst at lane 12 -> all outputs at reset values in the same cycle, and the next
//    block starts at bank0.

Source files
------------

// File: rtl/perm_types_pkg.sv
// Shared types for the perm_blk input loader: lane/coordinate widths and per-bank state.
package perm_types_pkg;
    localparam int W     = 64;
    localparam int LANES = 25;
    localparam logic [4:0] LAST_LANE = 5'(LANES - 1);

    typedef logic [W-1:0] lane_t;
    typedef logic [2:0]   coord_t;
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, BUSY} bank_st_e;
endpackage

// File: rtl/perm_bank_ctl.sv
// Lifecycle of one m55 bank: EMPTY -> FILLING -> FULL -> BUSY -> EMPTY.
// A release is applied before the other transitions in the same cycle.
module perm_bank_ctl
    import perm_types_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     start,
    input  logic     done,
    input  logic     take,
    input  logic     rel,
    output bank_st_e st,
    output bank_st_e st_nxt,
    output logic     rel_err
);

    always_comb begin
        st_nxt  = st;
        rel_err = 1'b0;
        if (rel) begin
            if (st == BUSY) st_nxt = EMPTY;
            else            rel_err = 1'b1;
        end
        case (st)
            EMPTY:   if (start) st_nxt = FILLING;
            FILLING: if (done)  st_nxt = FULL;
            FULL:    if (take)  st_nxt = BUSY;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= EMPTY;
        else     st <= st_nxt;
    end

endmodule

// File: rtl/perm_in_loader.sv
// Loads 25-lane blocks into ping-pong banks; 1-cycle write latency, bank FULL one cycle later.
// Backpressure: registered stopin when the next bank to fill is still FULL/BUSY; pushes under stopin are dropped.
module perm_in_loader
    import perm_types_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   pushin,
    input  logic   firstin,
    input  lane_t  din,
    output logic   stopin,
    output coord_t m0wx,
    output coord_t m0wy,
    output logic   m0wr,
    output lane_t  m0wd,
    output coord_t m1wx,
    output coord_t m1wy,
    output logic   m1wr,
    output lane_t  m1wd,
    output logic   blk_valid,
    output logic   blk_bank,
    input  logic   blk_ready,
    input  logic   rel,
    input  logic   rel_bank,
    output logic   err
);

    logic       fill, fill_nxt, last_q;
    logic [4:0] cnt, lidx;
    coord_t     cx, cy, wx, wy;
    bank_st_e   st0, st1, nx0, nx1, fst, fst_nxt;
    logic       rerr0, rerr1;
    logic       acc, first, perr, last, take;
    logic       stop_nxt, vld_nxt, bank_nxt;

    perm_bank_ctl u_bank0 (
        .clk(clk), .rst(rst),
        .start(acc & first & ~fill), .done(m0wr & last_q),
        .take(take & ~blk_bank), .rel(rel & ~rel_bank),
        .st(st0), .st_nxt(nx0), .rel_err(rerr0)
    );

    perm_bank_ctl u_bank1 (
        .clk(clk), .rst(rst),
        .start(acc & first & fill), .done(m1wr & last_q),
        .take(take & blk_bank), .rel(rel & rel_bank),
        .st(st1), .st_nxt(nx1), .rel_err(rerr1)
    );

    always_comb begin
        fst   = fill ? st1 : st0;
        acc   = 1'b0;
        first = 1'b0;
        perr  = 1'b0;
        if (pushin) begin
            if (stopin) begin
                perr = 1'b1;
            end else if (firstin) begin
                if (fst == EMPTY) begin
                    acc   = 1'b1;
                    first = 1'b1;
                end else if (fst == FILLING && cnt != 5'd0) begin
                    // abort the partial block and restart it in place
                    acc   = 1'b1;
                    first = 1'b1;
                    perr  = 1'b1;
                end else begin
                    perr = 1'b1;
                end
            end else if (fst == FILLING) begin
                acc = 1'b1;
            end else begin
                perr = 1'b1;
            end
        end

        lidx     = first ? 5'd0 : cnt;
        wx       = first ? 3'd0 : cx;
        wy       = first ? 3'd0 : cy;
        last     = acc && (lidx == LAST_LANE);
        fill_nxt = last ? ~fill : fill;
        take     = blk_valid & blk_ready;

        fst_nxt  = fill_nxt ? nx1 : nx0;
        stop_nxt = (fst_nxt == FULL) || (fst_nxt == BUSY);

        // an unaccepted offer is held so blk_bank never changes under valid
        vld_nxt  = blk_valid;
        bank_nxt = blk_bank;
        if (!(blk_valid && !blk_ready)) begin
            if (nx0 == FULL) begin
                vld_nxt  = 1'b1;
                bank_nxt = 1'b0;
            end else if (nx1 == FULL) begin
                vld_nxt  = 1'b1;
                bank_nxt = 1'b1;
            end else begin
                vld_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill      <= 1'b0;
            cnt       <= 5'd0;
            cx        <= 3'd0;
            cy        <= 3'd0;
            last_q    <= 1'b0;
            stopin    <= 1'b0;
            m0wr      <= 1'b0;
            m0wx      <= 3'd0;
            m0wy      <= 3'd0;
            m0wd      <= '0;
            m1wr      <= 1'b0;
            m1wx      <= 3'd0;
            m1wy      <= 3'd0;
            m1wd      <= '0;
            blk_valid <= 1'b0;
            blk_bank  <= 1'b0;
            err       <= 1'b0;
        end else begin
            m0wr <= acc & ~fill;
            m1wr <= acc & fill;
            if (acc && !fill) begin
                m0wx <= wx;
                m0wy <= wy;
                m0wd <= din;
            end
            if (acc && fill) begin
                m1wx <= wx;
                m1wy <= wy;
                m1wd <= din;
            end
            last_q <= last;
            fill   <= fill_nxt;
            if (last) begin
                cnt <= 5'd0;
                cx  <= 3'd0;
                cy  <= 3'd0;
            end else if (acc) begin
                cnt <= lidx + 5'd1;
                if (wx == 3'd4) begin
                    cx <= 3'd0;
                    cy <= wy + 3'd1;
                end else begin
                    cx <= wx + 3'd1;
                    cy <= wy;
                end
            end
            stopin    <= stop_nxt;
            blk_valid <= vld_nxt;
            blk_bank  <= bank_nxt;
            err       <= perr | rerr0 | rerr1;
        end
    end

endmodule

// File: tb/tb_perm_in_loader.sv
// Self-checking bench for perm_in_loader: directed table, corner sequences and random traffic vs a lane-level model.
module tb_perm_in_loader;
    import perm_types_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   pushin = 1'b0, firstin = 1'b0, blk_ready = 1'b0, rel = 1'b0, rel_bank = 1'b0;
    lane_t  din = '0;
    logic   stopin, m0wr, m1wr, blk_valid, blk_bank, err;
    coord_t m0wx, m0wy, m1wx, m1wy;
    lane_t  m0wd, m1wd;

    always #5 clk = ~clk;

    perm_in_loader dut (
        .clk(clk), .rst(rst), .pushin(pushin), .firstin(firstin), .din(din),
        .stopin(stopin),
        .m0wx(m0wx), .m0wy(m0wy), .m0wr(m0wr), .m0wd(m0wd),
        .m1wx(m1wx), .m1wy(m1wy), .m1wr(m1wr), .m1wd(m1wd),
        .blk_valid(blk_valid), .blk_bank(blk_bank), .blk_ready(blk_ready),
        .rel(rel), .rel_bank(rel_bank), .err(err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: bank status 0=empty 1=filling 2=full 3=busy
    int          bst[2];
    int          fb, lanes, pend;
    bit          e_stop, e_wr0, e_wr1, e_valid, e_bank, e_err;
    logic [2:0]  e_x, e_y;
    logic [63:0] e_d;

    task automatic model_reset();
        bst[0] = 0; bst[1] = 0;
        fb = 0; lanes = 0; pend = -1;
        e_stop = 0; e_wr0 = 0; e_wr1 = 0; e_valid = 0; e_bank = 0; e_err = 0;
        e_x = 0; e_y = 0; e_d = 0;
    endtask

    task automatic model_step(input bit p, input bit f, input logic [63:0] d,
                              input bit rdy, input bit rl, input bit rb);
        int nb[2];
        int L;
        nb[0] = bst[0]; nb[1] = bst[1];
        e_err = 0; e_wr0 = 0; e_wr1 = 0; L = -1;
        if (rl) begin
            if (bst[rb] == 3) nb[rb] = 0;
            else e_err = 1;
        end
        if (e_valid && rdy) nb[e_bank] = 3;
        if (pend >= 0) begin
            nb[pend] = 2;
            pend = -1;
        end
        if (p) begin
            if (e_stop) e_err = 1;
            else if (f) begin
                if (bst[fb] == 0) begin
                    L = 0; nb[fb] = 1;
                end else if (bst[fb] == 1 && lanes > 0) begin
                    L = 0; e_err = 1;
                end else e_err = 1;
            end else if (bst[fb] == 1) L = lanes;
            else e_err = 1;
        end
        if (L >= 0) begin
            if (fb == 0) e_wr0 = 1; else e_wr1 = 1;
            e_x = 3'(L % 5);
            e_y = 3'(L / 5);
            e_d = d;
            lanes = L + 1;
            if (L == LANES - 1) begin
                pend = fb;
                fb = 1 - fb;
                lanes = 0;
            end
        end
        bst[0] = nb[0]; bst[1] = nb[1];
        e_stop = (bst[fb] >= 2);
        if (!(e_valid && !rdy)) begin
            if (bst[0] == 2) begin
                e_valid = 1; e_bank = 0;
            end else if (bst[1] == 2) begin
                e_valid = 1; e_bank = 1;
            end else e_valid = 0;
        end
    endtask

    task automatic step(input bit p, input bit f, input logic [63:0] d,
                        input bit rdy, input bit rl, input bit rb);
        @(negedge clk);
        pushin = p; firstin = f; din = d; blk_ready = rdy; rel = rl; rel_bank = rb;
        @(posedge clk);
        model_step(p, f, d, rdy, rl, rb);
        #1;
        chk("status stop/wr0/wr1/valid/err", 80'({stopin, m0wr, m1wr, blk_valid, err}),
            80'({e_stop, e_wr0, e_wr1, e_valid, e_err}));
        if (e_valid) chk("blk_bank", 80'(blk_bank), 80'(e_bank));
        if (e_wr0) chk("m0 write x/y/d", 80'({m0wx, m0wy, m0wd}), 80'({e_x, e_y, e_d}));
        if (e_wr1) chk("m1 write x/y/d", 80'({m1wx, m1wy, m1wd}), 80'({e_x, e_y, e_d}));
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, " ctl"}, 80'({stopin, m0wr, m1wr, blk_valid, blk_bank, err}), 80'(0));
        chk({nm, " m0"}, 80'({m0wx, m0wy, m0wd}), 80'(0));
        chk({nm, " m1"}, 80'({m1wx, m1wy, m1wd}), 80'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; pushin = 0; firstin = 0; blk_ready = 0; rel = 0; rel_bank = 0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    typedef struct {
        bit p, f;
        logic [63:0] d;
        bit rdy, rl, rb;
        bit x_wr0, x_err, x_stop, x_valid;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 64'h7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 64'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 64'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 64'h13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Directed table straight out of reset
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].p, tbl[i].f, tbl[i].d, tbl[i].rdy, tbl[i].rl, tbl[i].rb);
            chk($sformatf("table[%0d] wr0/err/stop/valid", i),
                80'({m0wr, err, stopin, blk_valid}),
                80'({tbl[i].x_wr0, tbl[i].x_err, tbl[i].x_stop, tbl[i].x_valid}));
        end

        // One full block into bank0
        do_reset();
        for (int i = 0; i < 25; i++) begin
            step(1, i == 0, 64'(i), 0, 0, 0);
            if (i == 5)  chk("lane5 at (0,1)", 80'({m0wr, m0wx, m0wy, m0wd}), 80'({1'b1, 3'd0, 3'd1, 64'd5}));
            if (i == 24) chk("lane24 at (4,4)", 80'({m0wr, m0wx, m0wy, blk_valid}), 80'({1'b1, 3'd4, 3'd4, 1'b0}));
        end
        step(0, 0, 0, 0, 0, 0);
        chk("bank0 offered", 80'({blk_valid, blk_bank}), 80'(2'b10));

        // Second block into bank1 with the core stalled
        for (int i = 0; i < 25; i++) step(1, i == 0, 64'(100 + i), 0, 0, 0);
        chk("stop after both full", 80'({stopin, m1wr}), 80'(2'b11));
        step(1, 1, 64'd999, 0, 0, 0);
        chk("51st push dropped", 80'({err, m0wr, m1wr}), 80'(3'b100));

        // Take bank0, release it, refill it; bank1 is taken and released as bank0 completes
        step(0, 0, 0, 1, 0, 0);
        chk("bank1 offered after take", 80'({blk_valid, blk_bank, stopin}), 80'(3'b111));
        step(0, 0, 0, 0, 1, 0);
        chk("stop drops after rel0", 80'({stopin, err}), 80'(2'b00));
        for (int i = 0; i < 25; i++) begin
            step(1, i == 0, 64'(300 + i), i == 3, i == 24, 1);
            if (i == 0) chk("third block to m0", 80'({m0wr, m1wr, err}), 80'(3'b100));
        end
        chk("completion with rel of other", 80'({stopin, err}), 80'(2'b00));

        // firstin at lane 10 aborts and restarts the block
        do_reset();
        for (int i = 0; i < 10; i++) step(1, i == 0, 64'(i), 0, 0, 0);
        step(1, 1, 64'hAB, 0, 0, 0);
        chk("abort restart at (0,0)", 80'({err, m0wr, m0wx, m0wy, m0wd}), 80'({1'b1, 1'b1, 3'd0, 3'd0, 64'hAB}));
        for (int i = 1; i < 25; i++) step(1, 0, 64'(200 + i), 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("offer after restarted block", 80'({blk_valid, blk_bank}), 80'(2'b10));

        // Reset mid-block
        do_reset();
        for (int i = 0; i < 12; i++) step(1, i == 0, 64'(i), 0, 0, 0);
        rst = 1; pushin = 0; firstin = 0;
        #1;
        check_reset_outputs("async reset mid-block");
        @(negedge clk);
        rst = 0;
        model_reset();
        step(1, 1, 64'h55, 0, 0, 0);
        chk("restart at bank0", 80'({m0wr, m1wr, m0wx, m0wy}), 80'({1'b1, 1'b0, 3'd0, 3'd0}));

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit p, f, rdy, rl, rb;
            p   = ($urandom % 10) < 7;
            f   = (($urandom % 25) == 0) || (bst[fb] == 0 && ($urandom % 2) == 1);
            rdy = ($urandom % 4) == 0;
            rl  = ($urandom % 8) == 0;
            rb  = (bst[1] == 3 && bst[0] != 3) ? (($urandom % 8) != 0) : (($urandom % 8) == 0);
            step(p, f, {$urandom, $urandom}, rdy, rl, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
